rv32i_alu_seq: RTL

- RV32I execute-stage ALU, directly downstream of the operand-select stage; consumes its two 32-bit operand outputs plus a 4-bit ALU opcode from the decoder.
- Single-cycle for arithmetic, logic and compare ops.
- Shifts run iteratively, one bit per cycle, to save area.
- Start/busy/done handshake toward the control FSM; registered result with zero flag for branch evaluation.

---
 rtl/rv32i_alu_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rv32i_alu_seq.sv
// RV32I execute-stage ALU: start/busy/done handshake, registered result and zero flag.
// Define RV32I_ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; by default shifts run one bit per cycle.
module rv32i_alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [3:0]      aluOp,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_PASS = 4'hA;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    result_q, result_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  assign shamt = in2[SHAMT_W-1:0];

`ifdef RV32I_ALU_BARREL_SHIFT_EN
  logic [XLEN-1:0] sra_res;
  assign sra_res = $signed(in1) >>> shamt;
`endif

  always_comb begin
    alu_res = '0;
    case (aluOp)
      OP_ADD:  alu_res = in1 + in2;
      OP_SUB:  alu_res = in1 - in2;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in1 < in2};
      OP_XOR:  alu_res = in1 ^ in2;
      OP_OR:   alu_res = in1 | in2;
      OP_AND:  alu_res = in1 & in2;
      OP_PASS: alu_res = in2;
`ifdef RV32I_ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = in1 << shamt;
      OP_SRL:  alu_res = in1 >> shamt;
      OP_SRA:  alu_res = sra_res;
`else
      // Only reached with shamt == 0; nonzero amounts go through the iterative path.
      OP_SLL, OP_SRL, OP_SRA: alu_res = in1;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef RV32I_ALU_BARREL_SHIFT_EN
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (start) begin
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy = 1'b0;
`else
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    work_q, work_d, step;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               shl_q, shl_d;
  logic               arith_q, arith_d;
  logic               busy_q, busy_d;
  logic               is_shift;

  assign is_shift = (aluOp == OP_SLL) || (aluOp == OP_SRL) || (aluOp == OP_SRA);
  assign step = shl_q ? {work_q[XLEN-2:0], 1'b0}
                      : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    shl_d    = shl_q;
    arith_d  = arith_q;
    busy_d   = busy_q;
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            work_d  = in1;
            count_d = shamt;
            shl_d   = (aluOp == OP_SLL);
            arith_d = (aluOp == OP_SRA);
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = step;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d = step;
          zero_d   = (step == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      count_q  <= '0;
      shl_q    <= 1'b0;
      arith_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      shl_q    <= shl_d;
      arith_q  <= arith_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
`endif

  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
endmodule
